uart_rx_periph: RTL and testbench

//  APB slave UART receiver: the consumer of the serial line driven by the TX peripheral.

---
 rtl/uart_rx_pkg.sv | 34 +++
 rtl/uart_rx_core.sv | 163 ++++++++++++++++
 rtl/uart_rx_periph.sv | 152 +++++++++++++++
 tb/tb_uart_rx_periph.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the APB UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state type, APB register offsets, STATUS bit indices and
// the baud tick divider helper. Optional feature macro: UART_RX_PARITY_EN.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Register select values, compared against PADDR[3:2]
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;

  // STATUS register bit positions
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_FRAME   = 3;
  localparam int ST_PARITY  = 4;

  // Clocks per 16x oversampling tick
  function automatic int tick_div(input int clk_hz, input int baud);
    return clk_hz / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial de-framer: rx synchronizer, 16x tick divider and receive FSM.
// Latency: byte_valid pulses in the cycle of the stop-bit sample.
// Backpressure: none; the consumer must accept every byte_valid pulse.
//
// Ports: clk, rst (async active-high); rx (async serial in, idle high);
// byte_valid (1-cycle), byte_data[7:0], frame_err_p, parity_err_p (1-cycle).
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit).
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_p,
  output logic       parity_err_p
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          rx_s1, rx_s2;
  logic [DW-1:0] div_cnt;
  logic          tick;

  rx_state_e     state, state_n;
  logic [3:0]    tick_cnt, tick_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bad, par_bad_n;

  // Two-flop synchronizer, reset to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // Free-running divider: tick is high for one cycle every DIV clocks
  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      par_bad  <= par_bad_n;
    end
  end

  // tick_cnt is 4 bits, so +1 on the 16th tick wraps back to 0 by itself.
  always_comb begin
    state_n      = state;
    tick_cnt_n   = tick_cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    par_bad_n    = par_bad;
    byte_valid   = 1'b0;
    frame_err_p  = 1'b0;
    parity_err_p = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s2) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end

      START: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          // Middle of the start bit: a high line here was only a glitch
          if (tick_cnt == 4'd7) begin
            tick_cnt_n = '0;
            bit_idx_n  = '0;
            par_bad_n  = 1'b0;
            state_n    = rx_s2 ? IDLE : DATA;
          end
        end
      end

      DATA: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shreg_n   = {rx_s2, shreg[7:1]};
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end
        end
      end

      PARITY: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            par_bad_n = (rx_s2 != ^shreg);
            state_n   = STOP;
          end
        end
      end

      STOP: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            if (rx_s2) begin
              byte_valid   = !par_bad;
              parity_err_p = par_bad;
              state_n      = IDLE;
            end else begin
              // Missing stop bit: wait for the line to recover before hunting
              frame_err_p  = 1'b1;
              parity_err_p = par_bad;
              state_n      = WAIT_HIGH;
            end
          end
        end
      end

      WAIT_HIGH: begin
        if (rx_s2) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/uart_rx_periph.sv
// APB slave UART receiver: de-frames rx bytes into an RX FIFO, sticky error flags.
// Latency: APB access completes one cycle after PENABLE (registered PREADY/PRDATA).
// Backpressure: none on rx; a push into a full FIFO drops the byte and sets overrun.
//
// Ports: PCLK, PRESET (async active-high); APB PADDR[3:0], PWDATA[31:0], PWRITE,
// PENABLE, PSEL -> PRDATA[31:0], PREADY; rx (serial in); rx_irq (FIFO not empty).
// Optional feature macro: UART_RX_PARITY_EN (even parity, STATUS[4] parity_err).
module uart_rx_periph
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int DIV   = tick_div(CLK_HZ, BAUD);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             frame_err_p;
  logic             parity_err_p;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, push_ok, pop, ovr_set;

  logic             access, rd_acc, wr_acc, w1c;
  logic [1:0]       sel;
  logic [31:0]      status_word, rd_word;
  logic             overrun_q, frame_q, parity_q;
  logic             unused_bits;

  uart_rx_core #(.DIV(DIV)) u_core (
    .clk          (PCLK),
    .rst          (PRESET),
    .rx           (rx),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .frame_err_p  (frame_err_p),
    .parity_err_p (parity_err_p)
  );

  // APB decode: the !PREADY term limits each transfer to a single access
  assign access = PSEL & PENABLE & ~PREADY;
  assign rd_acc = access & ~PWRITE;
  assign wr_acc = access & PWRITE;
  assign sel    = PADDR[3:2];
  assign w1c    = wr_acc && (sel == REG_STATUS);

  // FIFO control; a pop frees a slot in the same cycle, so push_ok holds when full
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = rd_acc && (sel == REG_DATA) && !empty;
  assign push_ok = byte_valid && (!full || pop);
  assign ovr_set = byte_valid && full && !pop;

  always_ff @(posedge PCLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= byte_data;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      overrun_q <= (overrun_q & ~(w1c & PWDATA[ST_OVERRUN])) | ovr_set;
      frame_q   <= (frame_q & ~(w1c & PWDATA[ST_FRAME])) | frame_err_p;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= (parity_q & ~(w1c & PWDATA[ST_PARITY])) | parity_err_p;
    end
  end
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:5], PWDATA[1:0]};
`else
  assign parity_q    = 1'b0;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:4], PWDATA[1:0], parity_err_p};
`endif

  always_comb begin
    status_word              = '0;
    status_word[ST_EMPTY]    = empty;
    status_word[ST_FULL]     = full;
    status_word[ST_OVERRUN]  = overrun_q;
    status_word[ST_FRAME]    = frame_q;
    status_word[ST_PARITY]   = parity_q;
  end

  always_comb begin
    rd_word = '0;
    if (sel == REG_STATUS) begin
      rd_word = status_word;
    end else if (sel == REG_DATA && !empty) begin
      rd_word = {24'd0, mem[rd_ptr]};
    end
  end

  // PREADY stays high while PENABLE is held, dropping the cycle after it falls
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PRDATA <= '0;
      PREADY <= 1'b0;
    end else begin
      PREADY <= access | (PREADY & PENABLE);
      if (access) begin
        PRDATA <= PWRITE ? 32'd0 : rd_word;
      end
    end
  end

  assign rx_irq = !empty;

endmodule

// File: tb/tb_uart_rx_periph.sv
// Scoreboard bench for uart_rx_periph: APB reads push expected words,
// a negedge monitor pops and compares on each completed read.
// Runs at DIV=10 (160 clocks per bit); parity cases need UART_RX_PARITY_EN.
module tb_uart_rx_periph;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA    = BIT_CLKS;
`else
  localparam int EXTRA    = 0;
`endif

  logic        PCLK;
  logic        PRESET;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        rx;
  logic        rx_irq;

  typedef struct {
    logic [31:0] val;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   frame_cyc = 0;
  int   irq_rise_cyc = -1;
  logic ready_prev = 1'b0;
  logic irq_prev = 1'b0;

  uart_rx_periph #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .rx      (rx),
    .rx_irq  (rx_irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: one compare per completed read (rising PREADY with PWRITE low)
  always @(negedge PCLK) begin
    if (PREADY && !ready_prev && !PWRITE) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got %h expected no read", PRDATA);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("read_t%0d", e.tag), PRDATA, e.val);
      end
    end
    ready_prev = PREADY;
  end

  always @(negedge PCLK) begin
    if (rx_irq && !irq_prev) irq_rise_cyc = cyc;
    irq_prev = rx_irq;
  end

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata);
    int n;
    @(posedge PCLK);
    #1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    @(posedge PCLK);
    #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(posedge PCLK);
      #1;
      n++;
    end while (!PREADY && n < 20);
    if (!PREADY) begin
      tests++;
      fails++;
      $display("FAIL apb_timeout: got PREADY=0 expected 1 within 20 clk (addr %h)", addr);
    end
    @(posedge PCLK);
    #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, input logic [31:0] exp, input int tag);
    exp_t x;
    x.val = exp;
    x.tag = tag;
    exp_q.push_back(x);
    apb_xfer(1'b0, addr, 32'd0);
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    apb_xfer(1'b1, addr, data);
  endtask

  task automatic drive_bit(input logic b);
    #1 rx = b;
    repeat (BIT_CLKS) @(posedge PCLK);
  endtask

  // One frame: start, 8 data LSB first, [even parity ^ par_flip], stop bit value
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    @(posedge PCLK);
    #1 rx = 1'b0;
    frame_cyc = cyc;
    repeat (BIT_CLKS) @(posedge PCLK);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    #1 rx = 1'b1;
    repeat (n * BIT_CLKS) @(posedge PCLK);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET  = 1'b1;
    PADDR   = '0;
    PWDATA  = '0;
    PWRITE  = 1'b0;
    PENABLE = 1'b0;
    PSEL    = 1'b0;
    rx      = 1'b1;

    // 1: reset state
    repeat (4) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_irq", {31'd0, rx_irq}, 32'd0);
    #1 PRESET = 1'b0;
    repeat (4) @(posedge PCLK);
    apb_read(4'h0, 32'h1, 1);
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("idle_pready", {31'd0, PREADY}, 32'd0);
    check("idle_irq", {31'd0, rx_irq}, 32'd0);

    // 2: single byte, irq timing measured from the start-bit edge
    irq_rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(1);
    tests++;
    if (irq_rise_cyc < 0 || (irq_rise_cyc - frame_cyc) < 1512 + EXTRA ||
        (irq_rise_cyc - frame_cyc) > 1526 + EXTRA) begin
      fails++;
      $display("FAIL irq_timing: got %0d clk expected %0d..%0d", irq_rise_cyc - frame_cyc,
               1512 + EXTRA, 1526 + EXTRA);
    end
    check("irq_after_byte", {31'd0, rx_irq}, 32'd1);
    apb_read(4'h4, 32'hA5, 2);
    apb_read(4'h0, 32'h1, 2);
    @(negedge PCLK);
    check("irq_after_pop", {31'd0, rx_irq}, 32'd0);

    // 3: overrun with five bytes into a four-entry FIFO
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0);
    idle_bits(1);
    apb_read(4'h0, 32'h06, 3);
    for (int b = 1; b <= 4; b++) apb_read(4'h4, 32'(b), 3);
    apb_read(4'h4, 32'h0, 3);
    apb_write(4'h0, 32'h4);
    apb_read(4'h0, 32'h1, 3);

    // 4: missing stop bit followed by a stuck-low line, then a clean byte
    send_frame(8'h3C, 1'b0, 1'b0);
    #1 rx = 1'b0;
    repeat (3 * BIT_CLKS) @(posedge PCLK);
    idle_bits(2);
    apb_read(4'h0, 32'h09, 4);
    apb_write(4'h0, 32'h8);
    apb_read(4'h0, 32'h01, 4);
    send_frame(8'h55, 1'b1, 1'b0);
    idle_bits(1);
    apb_read(4'h4, 32'h55, 4);
    apb_read(4'h0, 32'h01, 4);

    // 5: 40-clock start glitch, then a normal byte
    @(posedge PCLK);
    #1 rx = 1'b0;
    repeat (40) @(posedge PCLK);
    idle_bits(2);
    apb_read(4'h0, 32'h01, 5);
    check("glitch_irq", {31'd0, rx_irq}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(1);
    apb_read(4'h4, 32'h7E, 5);
    apb_read(4'h0, 32'h01, 5);

    // 6: reset in the middle of the data bits with a byte already buffered
    send_frame(8'h11, 1'b1, 1'b0);
    idle_bits(1);
    @(negedge PCLK);
    check("pre_reset_irq", {31'd0, rx_irq}, 32'd1);
    @(posedge PCLK);
    #1 rx = 1'b0;
    repeat (BIT_CLKS) @(posedge PCLK);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (BIT_CLKS / 2) @(posedge PCLK);
    #1 PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 begin
      PRESET = 1'b0;
      rx     = 1'b1;
    end
    @(negedge PCLK);
    check("reset_irq", {31'd0, rx_irq}, 32'd0);
    idle_bits(2);
    apb_read(4'h0, 32'h01, 6);
    send_frame(8'h9C, 1'b1, 1'b0);
    idle_bits(1);
    apb_read(4'h4, 32'h9C, 6);
    apb_read(4'h0, 32'h01, 6);

`ifdef UART_RX_PARITY_EN
    // 7: parity error drops the byte; correct parity is accepted
    send_frame(8'h03, 1'b1, 1'b1);
    idle_bits(1);
    apb_read(4'h0, 32'h11, 7);
    apb_write(4'h0, 32'h10);
    apb_read(4'h0, 32'h01, 7);
    send_frame(8'h03, 1'b1, 1'b0);
    idle_bits(1);
    apb_read(4'h4, 32'h03, 7);
    apb_read(4'h0, 32'h01, 7);
`endif

    repeat (4) @(posedge PCLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
